// File: rtl/stream_merge_arbiter.sv
// N-to-1 round-robin merger of stb/ack word streams with sticky exception aggregation.
// Latency: word accepted on edge N is presented on output_out with output_out_stb high from N+1.
// Backpressure: a single registered slot; no input is acked until output_out_ack drains it.
// Optional feature macro STREAM_MERGE_TAG_EN adds output_out_tag (granted channel index).
module stream_merge_arbiter #(
  parameter int                     WIDTH    = 32,
  parameter int                     CHANNELS = 4,
  parameter int                     IDXW     = 2,
  parameter logic [CHANNELS-1:0]    EXC_MASK = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] input_in,
  input  logic [CHANNELS-1:0]       input_in_stb,
  output logic [CHANNELS-1:0]       input_in_ack,
  output logic [WIDTH-1:0]          output_out,
  output logic                      output_out_stb,
  input  logic                      output_out_ack,
`ifdef STREAM_MERGE_TAG_EN
  output logic [IDXW-1:0]           output_out_tag,
`endif
  input  logic [CHANNELS-1:0]       exception_in,
  output logic                      exception,
  output logic [IDXW-1:0]           exception_src
);

  typedef enum logic {ARB, SEND} state_t;

  state_t              state, state_nxt;
  logic [IDXW-1:0]     ptr;
  logic [IDXW-1:0]     gnt;
  logic [IDXW-1:0]     win;
  logic                found;
  int                  cand;
  logic [CHANNELS-1:0] exc_hit;
  logic [IDXW-1:0]     exc_low;

  // Round-robin search: first requesting channel at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = (int'(ptr) + k) % CHANNELS;
      if (!found && input_in_stb[cand]) begin
        found = 1'b1;
        win   = IDXW'(cand);
      end
    end
  end

  // Next state and the combinational ack; ack is forced low while reset is held.
  always_comb begin
    state_nxt    = state;
    input_in_ack = '0;
    case (state)
      ARB: begin
        if (found) begin
          state_nxt = SEND;
          if (rst) input_in_ack = CHANNELS'(1) << win;
        end
      end
      SEND: begin
        if (output_out_ack) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB;
    else      state <= state_nxt;
  end

  // Output slot, grant record and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_out     <= '0;
      output_out_stb <= 1'b0;
      gnt            <= '0;
      ptr            <= '0;
    end else if (state == ARB) begin
      if (found) begin
        output_out     <= input_in[int'(win)*WIDTH +: WIDTH];
        output_out_stb <= 1'b1;
        gnt            <= win;
      end
    end else if (output_out_ack) begin
      output_out_stb <= 1'b0;
      ptr            <= (gnt == IDXW'(CHANNELS-1)) ? '0 : gnt + 1'b1;
    end
  end

`ifdef STREAM_MERGE_TAG_EN
  assign output_out_tag = gnt;
`endif

  // Lowest unmasked channel currently raising an exception.
  always_comb begin
    exc_hit = exception_in & EXC_MASK;
    exc_low = '0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (exc_hit[i]) exc_low = IDXW'(i);
    end
  end

  // Sticky exception; the source is captured only on the first detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exception     <= 1'b0;
      exception_src <= '0;
    end else if (!exception && (|exc_hit)) begin
      exception     <= 1'b1;
      exception_src <= exc_low;
    end
  end

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// Directed table-driven bench for stream_merge_arbiter (CHANNELS=4, EXC_MASK=4'b1011).
// Each table row is one clock cycle: inputs driven after the edge, outputs checked at negedge.
// Exception aggregation is covered by a hand-written sequence after the table.
module tb_stream_merge_arbiter;

  localparam int W = 32;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [C*W-1:0] input_in;
  logic [C-1:0]   input_in_stb;
  logic [C-1:0]   input_in_ack;
  logic [W-1:0]   output_out;
  logic           output_out_stb;
  logic           output_out_ack;
  logic [C-1:0]   exception_in;
  logic           exception;
  logic [1:0]     exception_src;
`ifdef STREAM_MERGE_TAG_EN
  logic [1:0]     output_out_tag;
`endif

  stream_merge_arbiter #(.WIDTH(W), .CHANNELS(C), .IDXW(2), .EXC_MASK(4'b1011)) dut (
    .clk            (clk),
    .rst            (rst),
    .input_in       (input_in),
    .input_in_stb   (input_in_stb),
    .input_in_ack   (input_in_ack),
    .output_out     (output_out),
    .output_out_stb (output_out_stb),
    .output_out_ack (output_out_ack),
`ifdef STREAM_MERGE_TAG_EN
    .output_out_tag (output_out_tag),
`endif
    .exception_in   (exception_in),
    .exception      (exception),
    .exception_src  (exception_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0]   stb;
    logic [C*W-1:0] dat;
    logic           oack;
    logic [C-1:0]   ack;
    logic           ostb;
    logic [W-1:0]   out;
    logic [1:0]     tag;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [C*W-1:0] D_RR = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [C*W-1:0] D_BP = {32'hA3, 32'h1234, 32'hA1, 32'hA0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [C-1:0] stb, input logic [C*W-1:0] dat, input logic oack,
                     input logic [C-1:0] ack, input logic ostb, input logic [W-1:0] out,
                     input logic [1:0] tag);
    vec_t v;
    v.stb = stb; v.dat = dat; v.oack = oack;
    v.ack = ack; v.ostb = ostb; v.out = out; v.tag = tag;
    tbl.push_back(v);
  endtask

  initial begin
    // Round robin, all channels requesting, downstream always ready.
    add(4'b1111, D_RR, 1'b1, 4'b0001, 1'b0, 32'h0,  2'd0);
    add(4'b1111, D_RR, 1'b1, 4'b0000, 1'b1, 32'hA0, 2'd0);
    add(4'b1111, D_RR, 1'b1, 4'b0010, 1'b0, 32'hA0, 2'd0);
    add(4'b1111, D_RR, 1'b1, 4'b0000, 1'b1, 32'hA1, 2'd1);
    add(4'b1111, D_RR, 1'b1, 4'b0100, 1'b0, 32'hA1, 2'd0);
    add(4'b1111, D_RR, 1'b1, 4'b0000, 1'b1, 32'hA2, 2'd2);
    add(4'b1111, D_RR, 1'b1, 4'b1000, 1'b0, 32'hA2, 2'd0);
    add(4'b1111, D_RR, 1'b1, 4'b0000, 1'b1, 32'hA3, 2'd3);
    add(4'b1111, D_RR, 1'b1, 4'b0001, 1'b0, 32'hA3, 2'd0);
    add(4'b1111, D_RR, 1'b1, 4'b0000, 1'b1, 32'hA0, 2'd0);
    // Backpressure: single request on channel 2, stalled for 5 cycles.
    add(4'b0100, D_BP, 1'b0, 4'b0100, 1'b0, 32'hA0,   2'd0);
    for (int i = 0; i < 5; i++)
      add(4'b0110, D_BP, 1'b0, 4'b0000, 1'b1, 32'h1234, 2'd2);
    add(4'b0110, D_BP, 1'b1, 4'b0000, 1'b1, 32'h1234, 2'd2);
    // ptr is now 3: requests on 1 and 2 give channel 1 first, then 2.
    add(4'b0110, D_BP, 1'b0, 4'b0010, 1'b0, 32'h1234, 2'd0);
    add(4'b0110, D_BP, 1'b1, 4'b0000, 1'b1, 32'hA1,   2'd1);
    add(4'b0100, D_BP, 1'b1, 4'b0100, 1'b0, 32'hA1,   2'd0);
    add(4'b0000, D_BP, 1'b1, 4'b0000, 1'b1, 32'h1234, 2'd2);
    // Idle: output_out_ack with stb low is ignored.
    add(4'b0000, D_BP, 1'b1, 4'b0000, 1'b0, 32'h1234, 2'd0);
    add(4'b0000, D_BP, 1'b1, 4'b0000, 1'b0, 32'h1234, 2'd0);

    // Reset hold with every channel requesting.
    rst = 1'b0;
    input_in = D_RR;
    input_in_stb = 4'b1111;
    output_out_ack = 1'b0;
    exception_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 64'(input_in_ack), 64'h0);
    check("reset_ostb", 64'(output_out_stb), 64'h0);
    check("reset_out", 64'(output_out), 64'h0);
    check("reset_exc", 64'(exception), 64'h0);
    check("reset_src", 64'(exception_src), 64'h0);
    input_in_stb = '0;
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      input_in       = tbl[i].dat;
      input_in_stb   = tbl[i].stb;
      output_out_ack = tbl[i].oack;
      @(negedge clk);
      check($sformatf("row%0d_ack", i), 64'(input_in_ack), 64'(tbl[i].ack));
      check($sformatf("row%0d_ostb", i), 64'(output_out_stb), 64'(tbl[i].ostb));
      check($sformatf("row%0d_out", i), 64'(output_out), 64'(tbl[i].out));
`ifdef STREAM_MERGE_TAG_EN
      if (tbl[i].ostb) check($sformatf("row%0d_tag", i), 64'(output_out_tag), 64'(tbl[i].tag));
`endif
    end

    // Exception: masked channel 2 must be ignored.
    @(posedge clk); #1;
    input_in_stb = '0;
    exception_in = 4'b0100;
    @(posedge clk); #1;
    exception_in = '0;
    @(negedge clk);
    check("exc_masked", 64'(exception), 64'h0);

    // Channels 1 and 3 together: lowest unmasked source (1) is recorded after one edge.
    @(posedge clk); #1;
    exception_in = 4'b1010;
    @(negedge clk);
    check("exc_latency", 64'(exception), 64'h0);
    @(posedge clk); #1;
    exception_in = '0;
    @(negedge clk);
    check("exc_set", 64'(exception), 64'h1);
    check("exc_src", 64'(exception_src), 64'h1);

    // Later events leave the sticky source untouched.
    @(posedge clk); #1;
    exception_in = 4'b0001;
    @(posedge clk); #1;
    exception_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("exc_sticky", 64'(exception), 64'h1);
    check("exc_src_sticky", 64'(exception_src), 64'h1);

    // Reset mid-SEND drops the held word and clears the exception.
    @(posedge clk); #1;
    input_in = D_RR;
    input_in_stb = 4'b1000;
    output_out_ack = 1'b0;
    @(posedge clk); #1;
    input_in_stb = '0;
    @(negedge clk);
    check("pre_rst_ostb", 64'(output_out_stb), 64'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_ostb", 64'(output_out_stb), 64'h0);
    check("mid_rst_exc", 64'(exception), 64'h0);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_merge_arbiter.md
# stream_merge_arbiter

Parametrised N-to-1 merger for the stb/ack word streams that connect generated process instances to shared board peripherals, e.g. several processes sharing one `rs232_tx` or `leds` port. Round-robin arbitration with a single registered output stage. Also aggregates the per-instance `exception` flags into one sticky exception that records its source. Sits in the top-level user design between process instances and an output port.

## Interface
- `WIDTH`, 32, data word width per channel.
- `CHANNELS`, 4, number of input streams (1..16).
- `IDXW`, 2, index width; must equal max(1, clog2(CHANNELS)).
- `EXC_MASK`, all ones (CHANNELS bits), per-channel enable for exception aggregation.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `input_in`  in  CHANNELS*WIDTH  flattened input words; channel i occupies bits [i*WIDTH +: WIDTH].
- `input_in_stb`  in  CHANNELS  per-channel word valid.
- `input_in_ack`  out  CHANNELS  per-channel accept; at most one bit high.
- `output_out`  out  WIDTH  merged output word.
- `output_out_stb`  out  1  output word valid.
- `output_out_ack`  in  1  downstream accept.
- `exception_in`  in  CHANNELS  exception flags from the process instances.
- `exception`  out  1  sticky aggregated exception.
- `exception_src`  out  IDXW  lowest unmasked channel that raised `exception_in` in the first cycle of detection.

## Operation
- Transfer rule: a word moves on a rising edge where stb and ack are both high on that link.
- FSM has two states, ARB and SEND. Reset state is ARB.
- ARB:
  - Winner g is the first channel with `input_in_stb` high, searching from pointer `ptr` upward and wrapping modulo CHANNELS.
  - `input_in_ack[g]` is driven high combinationally in the same cycle; no other ack bit is high.
  - On the edge: `output_out` ← word g, `output_out_stb` ← 1, state → SEND.
  - If no stb is high, all acks stay 0 and the FSM stays in ARB.
- SEND:
  - All `input_in_ack` bits are 0.
  - `output_out` and `output_out_stb` hold until an edge with `output_out_ack` high.
  - On that edge: `output_out_stb` ← 0, `ptr` ← (g+1) mod CHANNELS, state → ARB.
  - `output_out_ack` while `output_out_stb` is low is ignored.
- Fairness: with all channels continuously requesting, grant order is 0,1,…,CHANNELS-1,0. No channel waits more than CHANNELS grants.
- Sources must hold stb and data stable until acked. If a source drops stb before its ack, it is simply not granted.
- Exception aggregation:
  - `exception` is set on the first edge where (`exception_in` & `EXC_MASK`) ≠ 0.
  - `exception_src` latches on that same edge.
  - Both stay set until reset; later events do not update `exception_src`.
- CHANNELS = 1: `ptr` stays 0 and behaviour degenerates to a one-stage register slice.

## Timing
- Reset values, held while `rst` is low:
  - `output_out` = 0, `output_out_stb` = 0, `input_in_ack` = 0.
  - `exception` = 0, `exception_src` = 0, `ptr` = 0, state = ARB.
- Reset asserted mid-SEND discards the held word. The upstream transfer is already complete, so the word is lost; this is by design.
- Latency: input accepted on edge N gives `output_out_stb` high from N+1.
- Throughput: one word per 2 cycles maximum, 3+ cycles when downstream stalls.
- `input_in_ack` is combinational from `input_in_stb`, state and `ptr`. The path from `input_in_stb` to `input_in_ack` is the critical path; ack never depends on `output_out_ack`.
- Exception detection latency: 1 cycle from `exception_in` to `exception`.

## Configuration
- `STREAM_MERGE_TAG_EN` defined:
  - Adds port `output_out_tag`  out  IDXW, the granted channel index.
  - Registered with `output_out` and held during SEND; reset value 0.
- Not defined: the port is absent and the channel index is not exported. All other behaviour is identical.

## Test plan
- Reset hold: `rst`=0 with all `input_in_stb`=1 → all acks 0, `output_out_stb`=0, `exception`=0. Release reset → channel 0 acked in the first cycle.
- Round robin: CHANNELS=4, all stb high, words 0xA0..0xA3, `output_out_ack` tied 1 → outputs 0xA0,0xA1,0xA2,0xA3,0xA0, one word every 2 cycles.
- Backpressure: single request 0x1234 on channel 2, `output_out_ack`=0 for 5 cycles → `output_out`=0x1234 stable, `output_out_stb`=1, no new acks. Then ack=1 → stb low the next cycle, `ptr`=3.
- Wrap and skip: `ptr`=3, requests on channels 1 and 2 only → channel 1 granted first, then channel 2.
- Exception: `EXC_MASK`=4'b1011, pulse `exception_in`=4'b0100 → `exception` stays 0. Then pulse 4'b1010 → `exception`=1, `exception_src`=1, and it stays set after the pulse.
- Tag (macro on): grant channel 3 → `output_out_tag`=3 while `output_out_stb`=1.
